bsg_scan_pipe: RTL

Pipelined, runtime-configurable prefix-scan unit. It generalises the combinational parameterised scan and is intended for wide scans (for example, round-robin masks and parity/priority vectors) where a single-cycle log-depth tree misses timing. Each log2 level of the Kogge-Stone scan has its own register. Operation, scan direction and a sideband tag travel with each datum. The block uses a valid/ready handshake and supports backpressure, and bubbles collapse inside the pipe.

---
 rtl/bsg_scan_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bsg_scan_pipe.sv
// Pipelined Kogge-Stone prefix scan (xor/and/or/pass) with one register per log2 level.
// Each item carries its own op, direction and tag; bubbles collapse under backpressure.
module bsg_scan_pipe #(
  parameter int width_p     = 8,
  parameter int tag_width_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     data_i,
  input  logic [1:0]             op_i,
  input  logic                   lo_to_hi_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic [width_p-1:0]     data_o,
  output logic [tag_width_p-1:0] tag_o
);

  localparam int levels_lp = (width_p > 1) ? $clog2(width_p) : 1;

  // Handshake: input transfers on v_i & ready_o; output transfers on v_o & yumi_i.
  // ready_o depends only on yumi_i and the stage valids, never on v_i.

  logic [levels_lp-1:0]   v_st;
  logic [levels_lp-1:0]   dir_st;
  logic [1:0]             op_st   [levels_lp];
  logic [width_p-1:0]     data_st [levels_lp];
  logic [tag_width_p-1:0] tag_st  [levels_lp];

  logic [width_p-1:0] data_rev_i;
  logic [width_p-1:0] out_raw;
  logic [width_p-1:0] out_rev;

  genvar j, k;

  for (j = 0; j < width_p; j++) begin : g_rev
    assign data_rev_i[j] = data_i[width_p-1-j];
    assign out_rev[j]    = out_raw[width_p-1-j];
  end

  for (k = 0; k < levels_lp; k++) begin : g_stage
    localparam int shift_lp = 1 << k;

    logic                   v_up;
    logic                   dir_up;
    logic [1:0]             op_up;
    logic [width_p-1:0]     data_up;
    logic [tag_width_p-1:0] tag_up;
    logic [width_p-1:0]     data_sh;
    logic [width_p-1:0]     data_res;
    logic                   fill;
    logic                   adv;

    logic                   v_q,    v_d;
    logic                   dir_q,  dir_d;
    logic [1:0]             op_q,   op_d;
    logic [width_p-1:0]     data_q, data_d;
    logic [tag_width_p-1:0] tag_q,  tag_d;

    if (k == 0) begin : g_head
      // Lo-to-hi scans are run on the bit-reversed vector through the same tree.
      assign v_up    = v_i;
      assign dir_up  = lo_to_hi_i;
      assign op_up   = op_i;
      assign data_up = lo_to_hi_i ? data_rev_i : data_i;
      assign tag_up  = tag_i;
    end else begin : g_body
      assign v_up    = v_st[k-1];
      assign dir_up  = dir_st[k-1];
      assign op_up   = op_st[k-1];
      assign data_up = data_st[k-1];
      assign tag_up  = tag_st[k-1];
    end

    assign fill = (op_up == 2'd1);

    for (j = 0; j < width_p; j++) begin : g_sh
      if (j + shift_lp < width_p) begin : g_in
        assign data_sh[j] = data_up[j+shift_lp];
      end else begin : g_fill
        assign data_sh[j] = fill;
      end
    end

    assign data_res = (op_up == 2'd0) ? (data_up ^ data_sh) :
                      (op_up == 2'd1) ? (data_up & data_sh) :
                      (op_up == 2'd2) ? (data_up | data_sh) :
                                        data_up;

    // A stage moves if it or any stage downstream of it has a hole, or the sink takes.
    assign adv = yumi_i | ~(&v_st[levels_lp-1:k]);

    always_comb begin
      v_d    = v_q;
      dir_d  = dir_q;
      op_d   = op_q;
      data_d = data_q;
      tag_d  = tag_q;
      if (adv) begin
        v_d    = v_up;
        dir_d  = dir_up;
        op_d   = op_up;
        data_d = data_res;
        tag_d  = tag_up;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        v_q    <= 1'b0;
        dir_q  <= 1'b0;
        op_q   <= 2'd0;
        data_q <= '0;
        tag_q  <= '0;
      end else begin
        v_q    <= v_d;
        dir_q  <= dir_d;
        op_q   <= op_d;
        data_q <= data_d;
        tag_q  <= tag_d;
      end
    end

    assign v_st[k]    = v_q;
    assign dir_st[k]  = dir_q;
    assign op_st[k]   = op_q;
    assign data_st[k] = data_q;
    assign tag_st[k]  = tag_q;
  end

  assign out_raw = data_st[levels_lp-1];
  assign data_o  = dir_st[levels_lp-1] ? out_rev : out_raw;
  assign tag_o   = tag_st[levels_lp-1];
  assign v_o     = v_st[levels_lp-1];
  assign ready_o = yumi_i | ~(&v_st);

endmodule
